// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS32 pipeline: MEM-stage FSM states and the
// MEM/WB bundle that the memory stage registers toward write-back.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              MemtoReg;
        logic              RegWrite;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  rd;
    } wb_bundle_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory ack; saturates at MAX_WAIT and
// flags expiry so the MEM stage can abandon an unanswered access.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_o = (count_q == CNT_W'(MAX_WAIT));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS32 MEM stage: req/ack data-memory access with upstream stall, branch/jump
// redirect, and the registered MEM/WB outputs.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int REG_W    = mips_pkg::REG_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              jump_in,
    input  logic              branch_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic [DATA_W-1:0] branch_pc_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              pcsrc_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic              MemtoReg_WB,
    output logic              RegWrite_WB,
    output logic [DATA_W-1:0] read_data_WB,
    output logic [DATA_W-1:0] alu_out_WB,
    output logic [REG_W-1:0]  rd_WB,
    output logic              misalign_err,
    output logic              timeout_err
);

    mem_state_e        state_q, state_d;
    wb_bundle_t        wb_q, wb_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic pending;
    logic aligned;
    logic expired;

    assign pending = MemRead_in | MemWrite_in;
    assign aligned = (alu_out_in[1:0] == 2'b00);

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q == ACCESS),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        stall_out  = 1'b0;

        // Default WB content is a bubble carrying the current address/destination.
        wb_d.MemtoReg  = 1'b0;
        wb_d.RegWrite  = 1'b0;
        wb_d.read_data = '0;
        wb_d.alu_out   = alu_out_in;
        wb_d.rd        = rd_in;

        case (state_q)
            IDLE: begin
                if (pending) begin
                    if (aligned) begin
                        addr_d    = {alu_out_in[DATA_W-1:2], 2'b00};
                        wdata_d   = b_in;
                        we_d      = MemWrite_in;
                        state_d   = ACCESS;
                        stall_out = 1'b1;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    wb_d.MemtoReg = MemtoReg_in;
                    wb_d.RegWrite = RegWrite_in;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    // EX/MEM is held by the stall, so its inputs still describe this op.
                    wb_d.MemtoReg  = MemtoReg_in;
                    wb_d.RegWrite  = RegWrite_in;
                    wb_d.read_data = we_q ? '0 : dmem_rdata;
                    state_d        = IDLE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wb_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    assign pcsrc_out         = jump_in | (branch_in & zero_in);
    assign branch_target_out = branch_pc_in;

    assign MemtoReg_WB  = wb_q.MemtoReg;
    assign RegWrite_WB  = wb_q.RegWrite;
    assign read_data_WB = wb_q.read_data;
    assign alu_out_WB   = wb_q.alu_out;
    assign rd_WB        = wb_q.rd;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected WB bundles are queued at issue and
// popped by a monitor once the stage accepts the instruction (stall_out low).
module tb_mem_access_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemtoReg_in = 0, RegWrite_in = 0, jump_in = 0, branch_in = 0;
    logic        MemWrite_in = 0, MemRead_in = 0, zero_in = 0;
    logic [31:0] branch_pc_in = '0, alu_out_in = '0, b_in = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, stall_out, pcsrc_out;
    logic [31:0] dmem_addr, dmem_wdata, branch_target_out, read_data_WB, alu_out_WB;
    logic        MemtoReg_WB, RegWrite_WB, misalign_err, timeout_err;
    logic [4:0]  rd_WB;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .jump_in(jump_in),
        .branch_in(branch_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .branch_pc_in(branch_pc_in), .zero_in(zero_in), .alu_out_in(alu_out_in),
        .b_in(b_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .pcsrc_out(pcsrc_out), .branch_target_out(branch_target_out),
        .MemtoReg_WB(MemtoReg_WB), .RegWrite_WB(RegWrite_WB), .read_data_WB(read_data_WB),
        .alu_out_WB(alu_out_WB), .rd_WB(rd_WB),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    int          total = 0;
    int          bad = 0;
    wb_bundle_t  sb_q[$];
    logic        in_valid = 1'b0;
    int          ack_k = -1;
    logic [31:0] ack_data = '0;
    int          req_cycles = 0;
    int          stall_cycles = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic        exp_we = 1'b0;
    logic        last_pcsrc = 1'b0;
    logic [31:0] last_target = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic wb_bundle_t mk_wb(input logic m, input logic r, input logic [31:0] rdat,
                                         input logic [31:0] alu, input logic [4:0] rd);
        wb_bundle_t w;
        w.MemtoReg  = m;
        w.RegWrite  = r;
        w.read_data = rdat;
        w.alu_out   = alu;
        w.rd        = rd;
        return w;
    endfunction

    // Memory model: acks the k-th request cycle (k = ack_k, -1 = never) and checks
    // that the request fields stay at their expected values while dmem_req is high.
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                if (req_cycles == ack_k) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = ack_data;
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = 32'h0BAD_0BAD;
                end
                check("req_addr", dmem_addr, exp_addr);
                check("req_we", dmem_we, exp_we);
                check("req_wdata", dmem_wdata, exp_wdata);
                req_cycles++;
            end else begin
                dmem_ack = 1'b0;
            end
        end
    end

    // Monitor: an instruction accepted in one cycle shows its WB bundle in the next.
    initial begin
        logic       due;
        wb_bundle_t e;
        due = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (due) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.RegWrite) begin
                        check("wb_full", {MemtoReg_WB, RegWrite_WB, read_data_WB, alu_out_WB, rd_WB}, e);
                    end else begin
                        check("wb_ctl", {MemtoReg_WB, RegWrite_WB}, {e.MemtoReg, e.RegWrite});
                    end
                    $display("wb retire: m2r=%0d rw=%0d rdata=%h alu=%h rd=%0d", MemtoReg_WB,
                             RegWrite_WB, read_data_WB, alu_out_WB, rd_WB);
                end
            end
            #1;
            due = in_valid && !stall_out && reset;
        end
    end

    task automatic clear_inputs();
        MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
        jump_in = 0; branch_in = 0; zero_in = 0;
        alu_out_in = '0; b_in = '0; branch_pc_in = '0; rd_in = '0;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic jmp, input logic br, input logic z,
                         input logic [31:0] alu, input logic [31:0] b, input logic [31:0] bpc,
                         input logic [4:0] rd, input wb_bundle_t exp);
        bit done;
        @(negedge clk); #1;
        MemRead_in = mr; MemWrite_in = mw; MemtoReg_in = m2r; RegWrite_in = rw;
        jump_in = jmp; branch_in = br; zero_in = z;
        alu_out_in = alu; b_in = b; branch_pc_in = bpc; rd_in = rd;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        stall_cycles = 0;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            #2;
            last_pcsrc  = pcsrc_out;
            last_target = branch_target_out;
            if (stall_out) begin
                stall_cycles++;
                @(negedge clk); #1;
            end else begin
                done = 1;
            end
        end
        if (!done) check("consume_bound", stall_out, 1'b0);
        @(negedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, pcsrc_out,
              branch_target_out, MemtoReg_WB, RegWrite_WB, read_data_WB, alu_out_WB, rd_WB,
              misalign_err, timeout_err}, '0);
        reset = 1'b1;

        // ADD r5 = 0x10
        issue(0, 0, 0, 1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd5, mk_wb(0, 1, 32'h0, 32'h10, 5'd5));
        check("add_stall", stall_cycles, 0);

        // Load from 0x100, ack after 3 wait cycles
        exp_addr = 32'h100; exp_we = 0; exp_wdata = 32'h0;
        ack_k = 3; ack_data = 32'hDEAD_BEEF; req_cycles = 0;
        issue(1, 0, 1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 5'd8, mk_wb(1, 1, 32'hDEAD_BEEF, 32'h100, 5'd8));
        check("load_stall_cycles", stall_cycles, 4);
        check("load_req_cycles", req_cycles, 4);
        check("load_req_dropped", dmem_req, 1'b0);

        // Store 0x1234 to 0x204, ack immediately
        exp_addr = 32'h204; exp_we = 1; exp_wdata = 32'h1234;
        ack_k = 0; req_cycles = 0;
        issue(0, 1, 0, 0, 0, 0, 0, 32'h204, 32'h1234, 32'h0, 5'd0, mk_wb(0, 0, 32'h0, 32'h204, 5'd0));
        check("store_stall_cycles", stall_cycles, 1);
        check("store_req_cycles", req_cycles, 1);

        // Misaligned load at 0x102
        req_cycles = 0;
        issue(1, 0, 1, 1, 0, 0, 0, 32'h102, 32'h0, 32'h0, 5'd9, mk_wb(0, 0, 32'h0, 32'h102, 5'd9));
        check("misalign_stall", stall_cycles, 0);
        check("misalign_flag", misalign_err, 1'b1);
        check("misalign_no_req", req_cycles, 0);

        issue(0, 0, 0, 1, 0, 0, 0, 32'h7, 32'h0, 32'h0, 5'd3, mk_wb(0, 1, 32'h0, 32'h7, 5'd3));
        check("misalign_sticky", misalign_err, 1'b1);
        check("no_timeout_yet", timeout_err, 1'b0);

        // Load that never gets an ack
        exp_addr = 32'h300; exp_we = 0; exp_wdata = 32'h0;
        ack_k = -1; req_cycles = 0;
        issue(1, 0, 1, 1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 5'd4, mk_wb(0, 0, 32'h0, 32'h300, 5'd4));
        check("timeout_req_cycles", req_cycles, 16);
        check("timeout_stall_cycles", stall_cycles, 16);
        check("timeout_flag", timeout_err, 1'b1);
        check("timeout_req_dropped", dmem_req, 1'b0);

        issue(0, 0, 0, 1, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd2, mk_wb(0, 1, 32'h0, 32'h55, 5'd2));
        check("after_timeout_stall", stall_cycles, 0);

        // Branch/jump redirect
        issue(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, mk_wb(0, 0, 32'h0, 32'h0, 5'd0));
        check("beq_taken_pcsrc", last_pcsrc, 1'b1);
        check("beq_taken_target", last_target, 32'h40);
        issue(0, 0, 0, 0, 0, 1, 0, 32'h1, 32'h0, 32'h60, 5'd0, mk_wb(0, 0, 32'h0, 32'h1, 5'd0));
        check("beq_not_taken_pcsrc", last_pcsrc, 1'b0);
        issue(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h80, 5'd0, mk_wb(0, 0, 32'h0, 32'h0, 5'd0));
        check("jump_pcsrc", last_pcsrc, 1'b1);
        check("jump_target", last_target, 32'h80);

        // Reset pulsed in the middle of an outstanding access
        exp_addr = 32'h400; exp_we = 0; exp_wdata = 32'h0;
        ack_k = -1; req_cycles = 0;
        @(negedge clk); #1;
        MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; alu_out_in = 32'h400; rd_in = 5'd6;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midreset_req_active", req_cycles, 3);
        clear_inputs();
        reset = 1'b0;
        #1;
        check("midreset_outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_out, pcsrc_out,
              branch_target_out, MemtoReg_WB, RegWrite_WB, read_data_WB, alu_out_WB, rd_WB,
              misalign_err, timeout_err}, '0);
        @(negedge clk); #1;
        reset = 1'b1;

        issue(0, 0, 0, 1, 0, 0, 0, 32'h99, 32'h0, 32'h0, 5'd7, mk_wb(0, 1, 32'h0, 32'h99, 5'd7));
        check("post_reset_stall", stall_cycles, 0);

        repeat (2) @(negedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
